// File: rtl/fir_stream_pkg.sv
// Shared types and width helpers for the FIR stream driver and its FIFO.
package fir_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_LENGTH = 64;

    // Full-precision accumulator width of a LENGTH-tap filter on WIDTH-bit data.
    function automatic int acc_width(input int width, input int length);
        return 2 * width + $clog2(length);
    endfunction

    localparam int DEF_ACC_W = acc_width(DEF_WIDTH, DEF_LENGTH);

endpackage

// File: rtl/fir_stream_driver_if.sv
// Bundles the upstream sample stream, the filter-core handshake and the downstream result stream.
interface fir_stream_driver_if
    import fir_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W
) ();

    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] fir_input;
    logic             fir_input_valid;
    logic             fir_ready_for_input;
    logic [ACC_W-1:0] fir_output;
    logic             fir_output_valid;
    logic [ACC_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        input  s_data, s_valid,
        output s_ready,
        output fir_input, fir_input_valid,
        input  fir_ready_for_input, fir_output, fir_output_valid,
        output m_data, m_valid,
        input  m_ready
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready,
        input  fir_input, fir_input_valid,
        output fir_ready_for_input, fir_output, fir_output_valid,
        input  m_data, m_valid,
        output m_ready
    );

endinterface

// File: rtl/fir_stream_fifo.sv
// Small synchronous sample FIFO; head is readable combinationally so the issuing edge can latch it.
module fir_stream_fifo
    import fir_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [DEPTH-1:0] count_reg;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_reg == DEPTH'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = entries[rd_ptr_reg];

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_reg;
        always_ff @(posedge clk) begin
            if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
                entry_reg <= push_data;
            end
        end
        assign entries[gi] = entry_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fir_stream_driver.sv
// Feeds buffered samples to the FIR core one at a time and hands each result downstream,
// with a watchdog on the filter response and a count of delivered results.
module fir_stream_driver
    import fir_stream_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LENGTH     = DEF_LENGTH,
    parameter int ACC_W      = acc_width(WIDTH, LENGTH),
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 256,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_stream_driver_if.master  bus,
    output logic                 busy,
    output logic                 timeout_err,
    input  logic                 clear_err,
    output logic [CNT_W-1:0]     sample_count
);

    localparam int WD_W = $clog2(TIMEOUT);

    state_t                  state_reg;
    logic [WIDTH-1:0]        fir_input_reg;
    logic                    fir_input_valid_reg;
    logic [ACC_W-1:0]        m_data_reg;
    logic                    m_valid_reg;
    logic                    timeout_err_reg;
    logic [CNT_W-1:0]        sample_count_reg;
    logic [WD_W-1:0]         watchdog_reg;
    logic                    prev_valid_reg;

    logic [WIDTH-1:0]        fifo_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FIFO_DEPTH-1:0]   fifo_count;
    logic                    issue;
    logic                    rise;

    assign issue = (state_reg == IDLE) && !fifo_empty && bus.fir_ready_for_input;
    assign rise  = bus.fir_output_valid && !prev_valid_reg;

    fir_stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.s_valid),
        .push_data (bus.s_data),
        .pop       (issue),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.s_ready         = !fifo_full;
    assign bus.fir_input       = fir_input_reg;
    assign bus.fir_input_valid = fir_input_valid_reg;
    assign bus.m_data          = m_data_reg;
    assign bus.m_valid         = m_valid_reg;
    assign timeout_err         = timeout_err_reg;
    assign sample_count        = sample_count_reg;
    assign busy                = (state_reg != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg           <= IDLE;
            fir_input_reg       <= '0;
            fir_input_valid_reg <= 1'b0;
            m_data_reg          <= '0;
            m_valid_reg         <= 1'b0;
            timeout_err_reg     <= 1'b0;
            sample_count_reg    <= '0;
            watchdog_reg        <= '0;
            prev_valid_reg      <= 1'b0;
        end else begin
            // Tracked in every state so a level held over from the last result never re-triggers.
            prev_valid_reg <= bus.fir_output_valid;
            if (clear_err) timeout_err_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        fir_input_reg       <= fifo_head;
                        fir_input_valid_reg <= 1'b1;
                        watchdog_reg        <= '0;
                        state_reg           <= WAIT;
                    end
                end
                WAIT: begin
                    fir_input_valid_reg <= 1'b0;
                    if (rise) begin
                        m_data_reg  <= bus.fir_output;
                        m_valid_reg <= 1'b1;
                        state_reg   <= DRAIN;
                    end else if (watchdog_reg == WD_W'(TIMEOUT - 1)) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        watchdog_reg <= watchdog_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_valid_reg && bus.m_ready) begin
                        m_valid_reg      <= 1'b0;
                        sample_count_reg <= sample_count_reg + 1'b1;
                        state_reg        <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_driver.sv
// Randomised bench for fir_stream_driver with a behavioural filter model and result scoreboard.
module tb_fir_stream_driver;

    localparam int WIDTH = 16;
    localparam int ACC_W = 38;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        timeout_err;
    logic        clear_err;
    logic [31:0] sample_count;

    fir_stream_driver_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

    fir_stream_driver #(
        .WIDTH(WIDTH), .LENGTH(64), .ACC_W(ACC_W),
        .FIFO_DEPTH(4), .TIMEOUT(256), .CNT_W(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .clear_err    (clear_err),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Filter model controls and observations
    int               filt_lat    = 3;
    bit               filt_silent = 1'b0;
    bit               filt_hold   = 1'b0;
    int               pulse_cnt   = 0;
    bit               pend        = 1'b0;
    int               pend_cnt    = 0;
    logic [ACC_W-1:0] pend_data   = '0;
    logic [WIDTH-1:0] issued_q[$];
    logic [ACC_W-1:0] got_q[$];

    // The modelled filter returns twice its input.
    function automatic logic [ACC_W-1:0] ref_f(input logic [WIDTH-1:0] x);
        return ACC_W'(x) * ACC_W'(2);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            bus.fir_output_valid = 1'b0;
            bus.fir_output = '0;
        end else if (bus.fir_input_valid) begin
            issued_q.push_back(bus.fir_input);
            pulse_cnt++;
            pend      = !filt_silent;
            pend_cnt  = filt_lat;
            pend_data = ref_f(bus.fir_input);
        end else if (pend) begin
            pend_cnt--;
            if (pend_cnt == 1) bus.fir_output_valid = 1'b0;
            if (pend_cnt == 0) begin
                bus.fir_output       = pend_data;
                bus.fir_output_valid = 1'b1;
                pend                 = 1'b0;
            end
        end else if (!filt_hold) begin
            bus.fir_output_valid = 1'b0;
        end
        if (!rst && bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [WIDTH-1:0] x);
        bit acc;
        int n;
        n = 0;
        bus.s_data  = x;
        bus.s_valid = 1'b1;
        do begin
            acc = bus.s_ready;
            tick();
            n++;
        end while (!acc && n < 2000);
        bus.s_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_accept: sample %h not accepted within %0d cycles", x, n);
        end
    endtask

    task automatic wait_results(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 2000) begin
            tick();
            k++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL result_wait: results=%0d required=%0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.fir_input !== '0) begin errors++; $display("FAIL rst_fir_input: got %h want 0", bus.fir_input); end
        checks++; if (bus.fir_input_valid !== 1'b0) begin errors++; $display("FAIL rst_fir_input_valid: got %b want 0", bus.fir_input_valid); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
        checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL rst_m_data: got %h want 0", bus.m_data); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
        checks++; if (sample_count !== 32'd0) begin errors++; $display("FAIL rst_sample_count: got %0d want 0", sample_count); end
        rst = 1'b0;
        tick();
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b want 1", bus.s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        got_q.delete();
        bus.fir_ready_for_input = 1'b1;
        bus.m_ready = 1'b1;
        push_sample(16'h0005);
        tick();
        checks++; if (bus.fir_input_valid !== 1'b1 || bus.fir_input !== 16'h0005) begin
            errors++; $display("FAIL single_issue: valid=%b data=%h want 1/0005", bus.fir_input_valid, bus.fir_input); end
        tick();
        checks++; if (bus.fir_input_valid !== 1'b0 || bus.fir_input !== 16'h0005) begin
            errors++; $display("FAIL single_pulse_end: valid=%b data=%h want 0/0005", bus.fir_input_valid, bus.fir_input); end
        wait_results(1);
        tick();
        checks++; if (got_q.size() != 1 || got_q[0] !== 38'h000000000A) begin
            errors++; $display("FAIL single_m_data: n=%0d got %h want 000000000a", got_q.size(), got_q.size() > 0 ? got_q[0] : '0); end
        checks++; if (sample_count !== 32'd1) begin errors++; $display("FAIL single_count: got %0d want 1", sample_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
        $display("test_single: m_data=%h count=%0d", got_q.size() > 0 ? got_q[0] : '0, sample_count);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d[6];
        logic [31:0]      base;
        int               p0;
        for (int i = 0; i < 6; i++) d[i] = WIDTH'($urandom);
        got_q.delete();
        issued_q.delete();
        base = sample_count;
        p0   = pulse_cnt;
        bus.fir_ready_for_input = 1'b0;
        for (int i = 0; i < 4; i++) push_sample(d[i]);
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: s_ready=%b want 0", bus.s_ready); end
        bus.s_data  = d[4];
        bus.s_valid = 1'b1;
        repeat (3) tick();
        bus.s_valid = 1'b0;
        checks++; if (bus.s_ready !== 1'b0 || pulse_cnt != p0) begin
            errors++; $display("FAIL b2b_hold: s_ready=%b pulses=%0d want 0/%0d", bus.s_ready, pulse_cnt, p0); end
        bus.fir_ready_for_input = 1'b1;
        push_sample(d[4]);
        push_sample(d[5]);
        wait_results(6);
        repeat (10) tick();
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL b2b_count_results: got %0d want 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size() && i < issued_q.size(); i++) begin
            checks++;
            if (got_q[i] !== ref_f(d[i]) || issued_q[i] !== d[i]) begin
                errors++;
                $display("FAIL b2b_result%0d: issued %h result %h want %h/%h", i, issued_q[i], got_q[i], d[i], ref_f(d[i]));
            end
            $display("b2b result %0d: sample=%h m_data=%h", i, issued_q[i], got_q[i]);
        end
        checks++; if (sample_count !== base + 32'd6) begin errors++; $display("FAIL b2b_sample_count: got %0d want %0d", sample_count, base + 32'd6); end
    endtask

    task automatic test_timeout();
        logic [WIDTH-1:0] a, b;
        logic [31:0]      base;
        int               n;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        got_q.delete();
        base = sample_count;
        filt_silent = 1'b1;
        push_sample(a);
        n = 0;
        while (timeout_err !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++; if (n != 257) begin errors++; $display("FAIL timeout_latency: cycles=%0d want 257", n); end
        checks++; if (busy !== 1'b0 || bus.m_valid !== 1'b0 || sample_count !== base) begin
            errors++; $display("FAIL timeout_state: busy=%b m_valid=%b count=%0d want 0/0/%0d", busy, bus.m_valid, sample_count, base); end
        filt_silent = 1'b0;
        push_sample(b);
        wait_results(1);
        tick();
        checks++; if (got_q.size() != 1 || got_q[0] !== ref_f(b)) begin
            errors++; $display("FAIL timeout_next: got %h want %h", got_q.size() > 0 ? got_q[0] : '0, ref_f(b)); end
        checks++; if (sample_count !== base + 32'd1 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: count=%0d err=%b want %0d/1", sample_count, timeout_err, base + 32'd1); end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
        $display("test_timeout: latency=%0d next=%h", n, b);
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] c, d;
        logic [31:0]      base;
        int               n, p0;
        bit               stable;
        c = WIDTH'($urandom);
        d = WIDTH'($urandom);
        got_q.delete();
        base = sample_count;
        bus.m_ready = 1'b0;
        push_sample(c);
        push_sample(d);
        n = 0;
        while (bus.m_valid !== 1'b1 && n < 100) begin tick(); n++; end
        p0 = pulse_cnt;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.m_valid !== 1'b1 || bus.m_data !== ref_f(c)) stable = 1'b0;
            tick();
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_stable: m_valid=%b m_data=%h want 1/%h", bus.m_valid, bus.m_data, ref_f(c)); end
        checks++; if (pulse_cnt != p0 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_no_issue: pulses=%0d busy=%b want %0d/1", pulse_cnt, busy, p0); end
        bus.m_ready = 1'b1;
        tick();
        checks++; if (sample_count !== base + 32'd1 || bus.m_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: count=%0d m_valid=%b want %0d/0", sample_count, bus.m_valid, base + 32'd1); end
        wait_results(2);
        tick();
        checks++; if (got_q.size() != 2 || got_q[0] !== ref_f(c) || got_q[1] !== ref_f(d)) begin
            errors++; $display("FAIL bp_results: n=%0d want 2 results %h %h", got_q.size(), ref_f(c), ref_f(d)); end
        $display("test_backpressure: held %h, then %h", ref_f(c), ref_f(d));
    endtask

    task automatic test_hold_high();
        logic [WIDTH-1:0] e, f;
        logic [31:0]      base;
        e = WIDTH'($urandom);
        f = WIDTH'($urandom);
        got_q.delete();
        base = sample_count;
        filt_hold = 1'b1;
        push_sample(e);
        wait_results(1);
        repeat (3) tick();
        push_sample(f);
        wait_results(2);
        filt_hold = 1'b0;
        repeat (10) tick();
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL hold_count: results=%0d want 2", got_q.size()); end
        checks++; if (got_q.size() < 2 || got_q[0] !== ref_f(e) || got_q[1] !== ref_f(f)) begin
            errors++; $display("FAIL hold_data: first=%h second=%h want %h %h",
                got_q.size() > 0 ? got_q[0] : '0, got_q.size() > 1 ? got_q[1] : '0, ref_f(e), ref_f(f)); end
        checks++; if (sample_count !== base + 32'd2) begin errors++; $display("FAIL hold_sample_count: got %0d want %0d", sample_count, base + 32'd2); end
        $display("test_hold_high: results %0d", got_q.size());
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] g;
        int               p0;
        g = WIDTH'($urandom);
        got_q.delete();
        filt_silent = 1'b1;
        for (int i = 0; i < 4; i++) push_sample(WIDTH'($urandom));
        checks++; if (busy !== 1'b1 || bus.s_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_pre: busy=%b s_ready=%b want 1/1", busy, bus.s_ready); end
        rst = 1'b1;
        #1;
        checks++; if (bus.fir_input !== '0 || bus.fir_input_valid !== 1'b0 || bus.m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_async: fir_input=%h valid=%b m_valid=%b busy=%b want 0", bus.fir_input, bus.fir_input_valid, bus.m_valid, busy); end
        checks++; if (sample_count !== 32'd0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rmid_status: count=%0d err=%b want 0/0", sample_count, timeout_err); end
        repeat (2) tick();
        rst = 1'b0;
        filt_silent = 1'b0;
        p0 = pulse_cnt;
        tick();
        checks++; if (bus.s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_release: s_ready=%b busy=%b want 1/0", bus.s_ready, busy); end
        repeat (10) tick();
        checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL rmid_stale: pulses=%0d want %0d", pulse_cnt, p0); end
        push_sample(g);
        wait_results(1);
        tick();
        checks++; if (got_q.size() != 1 || got_q[0] !== ref_f(g) || sample_count !== 32'd1) begin
            errors++; $display("FAIL rmid_after: result=%h count=%0d want %h/1", got_q.size() > 0 ? got_q[0] : '0, sample_count, ref_f(g)); end
        $display("test_reset_mid: post-reset result %h", ref_f(g));
    endtask

    initial begin
        rst = 1'b1;
        clear_err = 1'b0;
        bus.s_data = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        bus.fir_ready_for_input = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_hold_high();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_stream_driver.md
Name: fir_stream_driver

Overview:
- Upstream-facing driver that feeds the FIRfilter core and collects its results.
- Accepts 16-bit samples on a valid/ready stream and buffers them in a small FIFO.
- Issues each sample to the filter as a one-cycle input_valid pulse, but only when the filter reports ready_for_input.
- Captures the filter result on the rising edge of output_valid and presents it downstream on a valid/ready stream, with a watchdog timeout and a sample counter.

Parameters:
WIDTH, 16, sample width (matches filter WIDTH)
LENGTH, 64, filter tap count; used only to derive ACC_W
ACC_W, 2*WIDTH+$clog2(LENGTH) = 38, filter output width
FIFO_DEPTH, 4, sample buffer entries (power of 2, >=2)
TIMEOUT, 256, max cycles in WAIT for output_valid
CNT_W, 32, width of the completed-sample counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
s_data  in  WIDTH  upstream sample
s_valid  in  1  upstream sample valid
s_ready  out  1  FIFO not full
fir_input  out  WIDTH  sample to filter (FIR_input)
fir_input_valid  out  1  one-cycle issue pulse (input_valid)
fir_ready_for_input  in  1  filter ready (ready_for_input)
fir_output  in  ACC_W  filter result (FIR_output)
fir_output_valid  in  1  filter result valid (output_valid)
m_data  out  ACC_W  captured result
m_valid  out  1  result valid, held until m_ready
m_ready  in  1  downstream accept
busy  out  1  FSM not IDLE or FIFO non-empty
timeout_err  out  1  sticky watchdog flag
clear_err  in  1  synchronous clear of timeout_err
sample_count  out  CNT_W  results delivered downstream, wraps

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - fir_input=0, fir_input_valid=0, m_data=0, m_valid=0, timeout_err=0, sample_count=0.
  - FIFO empty, so s_ready=1 once rst is low; busy=0; FSM in IDLE; watchdog=0; output_valid edge register=0.
- Reset mid-operation flushes the FIFO, drops any in-flight sample and clears pending m_valid.
- FIFO:
  - Push on s_valid&&s_ready; s_ready=!full (combinational, registered count).
  - Pop only on the IDLE->WAIT transition.
  - No push when full, even if a pop occurs the same cycle. This is a simple rule that is acceptable for a 1-sample/issue rate.
  - Pointers wrap modulo FIFO_DEPTH; count is FIFO_DEPTH bits wide.
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE: when FIFO non-empty && fir_ready_for_input, at the edge: fir_input<=head, fir_input_valid<=1, pop, watchdog<=0, go WAIT.
  - WAIT:
    - fir_input_valid<=0 at the first WAIT edge, giving a pulse of exactly one cycle.
    - The watchdog increments each cycle.
    - On rise = fir_output_valid && !prev_valid: m_data<=fir_output, m_valid<=1, go DRAIN.
    - If the watchdog reaches TIMEOUT-1 without a rise: timeout_err<=1, sample dropped, count unchanged, go IDLE.
    - If rise and timeout occur in the same cycle, the rise wins.
  - DRAIN: when m_valid&&m_ready: m_valid<=0, sample_count<=sample_count+1 (wrapping), go IDLE.
- prev_valid is registered every cycle in every state, so a level-high output_valid held from a prior transaction does not re-trigger.
- fir_input holds its value after the pulse until the next issue.
- Latency:
  - Sample pushed at edge N with FSM idle and filter ready: fir_input_valid is high between edges N+1 and N+2.
  - Result rise sampled at edge M: m_valid is high from M.
  - Earliest next issue: the edge after the m_ready handshake.
- Throughput: exactly one sample in flight; no issue while m_valid is held.
- clear_err clears timeout_err at the edge; a same-cycle timeout set wins over clear.

Decomposition:
- Package fir_stream_pkg holds:
  - state enum (IDLE, WAIT, DRAIN);
  - default WIDTH/LENGTH/ACC_W constants;
  - function acc_width(width, length).
- One sub-module, fir_stream_fifo: parameterised synchronous FIFO with push/pop/full/empty/count.

Test Plan:
- Reset, then push 16'h0005; filter model ready, raises output_valid 3 cycles after the pulse with 38'h000000000A; m_ready=1 -> fir_input=16'h0005 with a one-cycle fir_input_valid; m_data=38'h000000000A; sample_count=1; busy returns to 0.
- Push 6 samples back-to-back (1..6) with filter ready low -> s_ready drops after 4 accepts. Then raise ready; results 1..6 arrive in order; sample_count=6.
- Filter never raises output_valid -> after 256 WAIT cycles timeout_err=1, FSM IDLE, next sample issued, sample_count unchanged. clear_err pulse -> timeout_err=0.
- Hold m_ready=0 for 20 cycles after a result -> m_valid and m_data stable; no new fir_input_valid. On m_ready=1 the count increments once.
- output_valid held high across two transactions, falling only between them -> each result captured once, with no spurious capture in WAIT.
- Assert rst in WAIT with 3 samples queued -> all outputs 0 immediately, FIFO empty, s_ready=1 after rst release, no stale pulse.
